// File: rtl/median_finder_stream.sv
// Streaming median: collects NUM samples into an insertion-sorted array, then emits one median per frame.
// Optional build macro MEDIAN_ROUND_EN: even-NUM average rounds half up instead of flooring.
module median_finder_stream #(
  parameter int DATA_W = 4,
  parameter int NUM    = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_median,
  output logic [$clog2(NUM+1)-1:0]   fill_cnt
);

  localparam int CNT_W = $clog2(NUM+1);

  typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_median_q, out_median_d;
  logic [DATA_W-1:0]  s_q [NUM];
  logic [DATA_W-1:0]  s_d [NUM];

  logic [NUM-1:0]     le;
  logic [DATA_W-1:0]  ins_val [NUM];
  logic [DATA_W-1:0]  median_calc;

  // le is a prefix of ones over the occupied entries because the array is ascending;
  // the first zero marks where in_data lands and everything above shifts up.
  for (genvar gi = 0; gi < NUM; gi++) begin : g_ins
    assign le[gi] = (gi < int'(fill_cnt_q)) && (s_q[gi] <= in_data);
    if (gi == 0) begin : g_first
      assign ins_val[gi] = le[gi] ? s_q[gi] : in_data;
    end else begin : g_rest
      assign ins_val[gi] = le[gi]     ? s_q[gi] :
                           le[gi-1]   ? in_data : s_q[gi-1];
    end
  end

  if (NUM % 2 == 1) begin : g_odd
    assign median_calc = s_q[(NUM-1)/2];
  end else begin : g_even
    logic [DATA_W:0] pair_sum;
    assign pair_sum = {1'b0, s_q[NUM/2-1]} + {1'b0, s_q[NUM/2]};
`ifdef MEDIAN_ROUND_EN
    assign median_calc = DATA_W'((pair_sum + (DATA_W+1)'(1)) >> 1);
`else
    assign median_calc = DATA_W'(pair_sum >> 1);
`endif
  end

  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_median_d = out_median_q;
    s_d          = s_q;
    case (state_q)
      LOAD: begin
        if (in_valid && in_ready_q) begin
          s_d        = ins_val;
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == CNT_W'(NUM-1)) begin
            state_d    = CALC;
            in_ready_d = 1'b0;
          end
        end
      end
      CALC: begin
        out_median_d = median_calc;
        out_valid_d  = 1'b1;
        state_d      = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d     = LOAD;
          fill_cnt_d  = '0;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = LOAD;
        fill_cnt_d  = '0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
    // Abort wins over everything; the array is left as-is since stale entries are never read.
    if (flush) begin
      state_d     = LOAD;
      fill_cnt_d  = '0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
      s_d         = s_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      fill_cnt_q   <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_median_q <= '0;
      for (int i = 0; i < NUM; i++) s_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_median_q <= out_median_d;
      s_q          <= s_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_median = out_median_q;
  assign fill_cnt   = fill_cnt_q;

endmodule

// File: tb/tb_median_finder_stream.sv
// Directed and random checks of median_finder_stream (NUM=6 main instance, NUM=5 side instance).
module tb_median_finder_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid;
  logic [3:0] out_median;
  logic [2:0] fill_cnt;

  logic       in_valid5 = 1'b0;
  logic [3:0] in_data5 = '0;
  logic       out_ready5 = 1'b0;
  logic       in_ready5, out_valid5;
  logic [3:0] out_median5;
  logic [2:0] fill_cnt5;

  median_finder_stream #(.DATA_W(4), .NUM(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_median(out_median),
    .fill_cnt(fill_cnt)
  );

  median_finder_stream #(.DATA_W(4), .NUM(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_median(out_median5),
    .fill_cnt(fill_cnt5)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int s[6];
    int exp;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // Reference: sort a copy, take the middle pair.
  function automatic int ref_med(input int v[6]);
    int a[6];
    int t, sum;
    a = v;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 5 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    sum = a[2] + a[3];
`ifdef MEDIAN_ROUND_EN
    return (sum + 1) / 2;
`else
    return sum / 2;
`endif
  endfunction

  task automatic send(input int d);
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'(d);
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) timeout("send");
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input int v[6], input int max_gap);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send(v[i]);
    end
  endtask

  task automatic recv(input string name, input int exp, input int delay);
    int t;
    @(negedge clk);
    t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) timeout(name);
    repeat (delay) @(negedge clk);
    chk({name, "_median"}, out_median, exp);
    chk({name, "_valid"}, out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({name, "_fill_after"}, fill_cnt, 0);
    chk({name, "_vld_after"}, out_valid, 0);
    chk({name, "_rdy_after"}, in_ready, 1);
    $display("frame %s: median=%0d expected=%0d", name, out_median, exp);
  endtask

  initial begin
    int v[6];
    int e, t;
    logic [3:0] held;

    tbl[0].s = '{2, 2, 5, 0, 9, 9};
`ifdef MEDIAN_ROUND_EN
    tbl[0].exp = 4;
`else
    tbl[0].exp = 3;
`endif
    tbl[1].s = '{15, 15, 15, 15, 15, 15}; tbl[1].exp = 15;
    tbl[2].s = '{4, 4, 4, 8, 8, 8};       tbl[2].exp = 6;
    tbl[3].s = '{0, 0, 0, 0, 0, 0};       tbl[3].exp = 0;
    tbl[4].s = '{6, 5, 4, 3, 2, 1};
`ifdef MEDIAN_ROUND_EN
    tbl[4].exp = 4;
`else
    tbl[4].exp = 3;
`endif

    #12;
    chk("rst_fill", fill_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_median", out_median, 0);
    @(negedge clk) rst_n = 1'b1;

    // Back-to-back frame with latency check.
    v = '{3, 7, 1, 9, 4, 6};
    for (int i = 0; i < 6; i++) begin
      send(v[i]);
      if (i < 5) chk("fill_progress", fill_cnt, i + 1);
    end
    chk("calc_fill", fill_cnt, 6);
    chk("calc_valid", out_valid, 0);
    chk("calc_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("latency_valid", out_valid, 1);
    recv("basic", 5, 0);

    for (int k = 0; k < 5; k++) begin
      send_frame(tbl[k].s, 0);
      recv($sformatf("tbl%0d", k), tbl[k].exp, 0);
    end

    // NUM=5 instance: middle element of 8,2,5,1,9.
    v = '{8, 2, 5, 1, 9, 0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid5 = 1'b1;
      in_data5  = 4'(v[i]);
      chk("n5_ready", in_ready5, 1);
      @(posedge clk);
      #1 in_valid5 = 1'b0;
    end
    t = 0;
    while (!out_valid5 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) timeout("n5");
    chk("n5_median", out_median5, 5);
    @(negedge clk) out_ready5 = 1'b1;
    @(posedge clk); #1 out_ready5 = 1'b0;
    chk("n5_fill_after", fill_cnt5, 0);

    // Stall in OUT with ignored input pulses, then accept next frame.
    v = '{1, 2, 3, 10, 11, 12};
    send_frame(v, 0);
    @(posedge clk); #1;
    held = out_median;
    chk("stall_median0", held, ref_med(v));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = c[0];
      in_data  = 4'd15;
      chk("stall_valid", out_valid, 1);
      chk("stall_median", out_median, held);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_fill", fill_cnt, 6);
    end
    @(negedge clk) in_valid = 1'b0;
    recv("stall", ref_med(v), 0);
    send_frame(tbl[2].s, 0);
    recv("after_stall", 6, 0);

    // Flush mid-frame with a sample presented in the flush cycle.
    send(9); send(9); send(9);
    chk("pre_flush_fill", fill_cnt, 3);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_data = 4'd15;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_fill", fill_cnt, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_median_kept", out_median, 6);
    send_frame(tbl[2].s, 0);
    recv("after_flush", 6, 0);

    // Reset pulse while in OUT.
    send_frame(tbl[1].s, 0);
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) timeout("rst_out");
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_in_ready", in_ready, 1);
    chk("rst_out_fill", fill_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    send_frame(tbl[4].s, 0);
    recv("after_rst", tbl[4].exp, 0);

    // Random frames with input gaps and output back-pressure.
    for (int f = 0; f < 1000; f++) begin
      for (int i = 0; i < 6; i++) v[i] = int'($urandom_range(0, 15));
      e = ref_med(v);
      send_frame(v, 2);
      recv($sformatf("rnd%0d", f), e, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
